// File: rtl/unidade_controle.sv
// Control unit for a small 16-bit, 8-register processor.
// A four-step FSM decodes a 9-bit instruction into register enables and bus selects.
module unidade_controle (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic [8:0] instr,
    output logic [7:0] rIn,
    output logic       aIn,
    output logic       gIn,
    output logic [3:0] selBus,
    output logic       addSub,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_t;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    state_t     state;
    logic [8:0] ir;
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;

    assign op     = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= T0;
            ir    <= 9'h000;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= instr;
                        state <= T1;
                    end
                end
                T1:      state <= is_alu ? T2 : T0;
                T2:      state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Outputs depend only on the registered state and IR, never on run/instr.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        rIn    = 8'h00;
        aIn    = 1'b0;
        gIn    = 1'b0;
        selBus = 4'd0;
        addSub = 1'b0;
        busy   = (state != T0);
        done   = 1'b0;
        case (state)
            T1: begin
                case (op)
                    OP_MV: begin
                        selBus = {1'b0, ry};
                        rIn    = 8'h01 << rx;
                        done   = 1'b1;
                    end
                    OP_MVI: begin
                        selBus = SEL_DIN;
                        rIn    = 8'h01 << rx;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        selBus = {1'b0, rx};
                        aIn    = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                selBus = {1'b0, ry};
                gIn    = 1'b1;
                addSub = ir[6];
            end
            T3: begin
                selBus = SEL_G;
                rIn    = 8'h01 << rx;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed literal cases plus
// randomized traffic compared every cycle against a queue-based step model.
module tb_unidade_controle;

    logic       clock;
    logic       resetn;
    logic       run;
    logic [8:0] instr;
    logic [7:0] rIn;
    logic       aIn;
    logic       gIn;
    logic [3:0] selBus;
    logic       addSub;
    logic       busy;
    logic       done;

    unidade_controle dut (
        .clock  (clock),
        .resetn (resetn),
        .run    (run),
        .instr  (instr),
        .rIn    (rIn),
        .aIn    (aIn),
        .gIn    (gIn),
        .selBus (selBus),
        .addSub (addSub),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector: {rIn, aIn, gIn, selBus, addSub, busy, done}
    typedef logic [16:0] vec_t;

    int   n_tests;
    int   n_fail;
    bit   cmp_en;
    vec_t steps[$];

    function automatic vec_t mk(input logic [7:0] r, input logic a, input logic g,
                                input logic [3:0] s, input logic sub, input logic b,
                                input logic d);
        return {r, a, g, s, sub, b, d};
    endfunction

    function automatic vec_t dut_vec();
        return {rIn, aIn, gIn, selBus, addSub, busy, done};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got rIn=%h aIn=%b gIn=%b selBus=%0d addSub=%b busy=%b done=%b, expected rIn=%h aIn=%b gIn=%b selBus=%0d addSub=%b busy=%b done=%b",
                     name, $time, act[16:9], act[8], act[7], act[6:3], act[2], act[1], act[0],
                     exp[16:9], exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Model: an accepted instruction expands into the list of per-cycle
    // output vectors it must produce; idle cycles are all zero.
    task automatic expand(input logic [8:0] i);
        logic [2:0] op;
        logic [7:0] onehot;
        op     = i[8:6];
        onehot = 8'h01 << i[5:3];
        case (op)
            3'b000: steps.push_back(mk(onehot, 0, 0, {1'b0, i[2:0]}, 0, 1, 1));
            3'b001: steps.push_back(mk(onehot, 0, 0, 4'd9, 0, 1, 1));
            3'b010, 3'b011: begin
                steps.push_back(mk(8'h00, 1, 0, {1'b0, i[5:3]}, 0, 1, 0));
                steps.push_back(mk(8'h00, 0, 1, {1'b0, i[2:0]}, op[0], 1, 0));
                steps.push_back(mk(onehot, 0, 0, 4'd8, 0, 1, 1));
            end
            default: steps.push_back(mk(8'h00, 0, 0, 4'd0, 0, 1, 1));
        endcase
    endtask

    always @(posedge clock) begin
        if (!resetn)
            steps.delete();
        else if (steps.size() > 0)
            void'(steps.pop_front());
        else if (run)
            expand(instr);
    end

    always @(negedge clock) begin
        if (cmp_en)
            check("model", dut_vec(), (steps.size() > 0) ? steps[0] : '0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg(input string name, input vec_t exp);
        @(negedge clock);
        check(name, dut_vec(), exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cmp_en  = 1'b0;
        resetn  = 1'b0;
        run     = 1'b0;
        instr   = 9'h000;
        tick();
        tick();
        resetn = 1'b1;
        cmp_en = 1'b1;
        at_neg("reset_idle", '0);

        // mv R2,R5
        run = 1'b1; instr = 9'h015; tick();
        run = 1'b0; instr = 9'h000;
        at_neg("mv_t1", mk(8'h04, 0, 0, 4'd5, 0, 1, 1));
        at_neg("mv_idle", '0);

        // mvi R7
        run = 1'b1; instr = 9'h078; tick();
        run = 1'b0;
        at_neg("mvi_t1", mk(8'h80, 0, 0, 4'd9, 0, 1, 1));
        at_neg("mvi_idle", '0);

        // add R1,R3
        run = 1'b1; instr = 9'h08B; tick();
        run = 1'b0;
        at_neg("add_t1", mk(8'h00, 1, 0, 4'd1, 0, 1, 0));
        at_neg("add_t2", mk(8'h00, 0, 1, 4'd3, 0, 1, 0));
        at_neg("add_t3", mk(8'h02, 0, 0, 4'd8, 0, 1, 1));
        at_neg("add_idle", '0);

        // sub R0,R6 with run held and instr changed mid-instruction
        run = 1'b1; instr = 9'h0C6; tick();
        at_neg("sub_t1", mk(8'h00, 1, 0, 4'd0, 0, 1, 0));
        tick();
        instr = 9'h015;
        at_neg("sub_t2", mk(8'h00, 0, 1, 4'd6, 1, 1, 0));
        at_neg("sub_t3", mk(8'h01, 0, 0, 4'd8, 0, 1, 1));
        at_neg("sub_t0", '0);
        at_neg("b2b_mv_t1", mk(8'h04, 0, 0, 4'd5, 0, 1, 1));
        run = 1'b0;
        at_neg("b2b_idle", '0);

        // invalid opcode
        run = 1'b1; instr = 9'h1C0; tick();
        run = 1'b0;
        at_neg("inv_t1", mk(8'h00, 0, 0, 4'd0, 0, 1, 1));
        at_neg("inv_idle", '0);

        // reset during T2 of add R1,R3, with run high in the reset cycle
        run = 1'b1; instr = 9'h08B; tick();
        run = 1'b0;
        tick();
        resetn = 1'b0; run = 1'b1;
        tick();
        at_neg("rst_t0", '0);
        resetn = 1'b1; run = 1'b0;
        at_neg("rst_no_t3", '0);

        // XXX == YYY: add R3,R3
        run = 1'b1; instr = 9'h09B; tick();
        run = 1'b0;
        at_neg("same_t1", mk(8'h00, 1, 0, 4'd3, 0, 1, 0));
        at_neg("same_t2", mk(8'h00, 0, 1, 4'd3, 0, 1, 0));
        at_neg("same_t3", mk(8'h08, 0, 0, 4'd8, 0, 1, 1));

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int k = 0; k < 600; k++) begin
            tick();
            resetn = ($urandom_range(0, 39) != 0);
            run    = ($urandom_range(0, 2) != 0);
            instr  = 9'($urandom);
        end
        resetn = 1'b1;
        run    = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
